// File: rtl/apb_pkg.sv
// Shared widths, FSM state encoding and command record for the APB command requester.
package apb_pkg;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase cycle counter: clear loads 1 so the value equals the index of the current ACCESS cycle.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count_reg;
    logic [7:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = 8'd1;
        end else if (enable && count_reg != 8'hFF) begin
            count_next = count_reg + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= 8'd0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = (count_reg == 8'(TIMEOUT_CYC));

endmodule

// File: rtl/apb_cmd_master.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS transfers and
// reports read data, slave error and timeout on a one-cycle response pulse.
module apb_cmd_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_timeout,
    output logic [ADDR_W-1:0]   tim_paddr,
    output logic                tim_psel,
    output logic                tim_penable,
    output logic                tim_pwrite,
    output logic [DATA_W-1:0]   tim_pwdata,
    output logic [DATA_W/8-1:0] tim_pstrb,
    input  logic [DATA_W-1:0]   tim_prdata,
    input  logic                tim_pready,
    input  logic                tim_pslverr
);

    localparam int STRB_W = DATA_W / 8;

    apb_state_t  state_reg, state_next;
    apb_cmd_t    cmd_reg, cmd_next;
    logic        cmd_ready_reg, cmd_ready_next;
    logic        psel_reg, psel_next;
    logic        penable_reg, penable_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg, rsp_err_next;
    logic        rsp_timeout_reg, rsp_timeout_next;

    logic        cnt_clear;
    logic        cnt_enable;
    logic        cnt_expired;

    // Reads carry no payload: byte lanes of data and strobe are forced to zero.
    logic [DATA_W-1:0] masked_wdata;
    logic [STRB_W-1:0] masked_strb;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign masked_wdata[gi*8 +: 8] = cmd_write ? cmd_wdata[gi*8 +: 8] : 8'h00;
            assign masked_strb[gi]         = cmd_write & cmd_strb[gi];
        end
    endgenerate

    apb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk    (sys_clk),
        .srst   (sys_rst),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .expired(cnt_expired)
    );

    always_comb begin
        state_next       = state_reg;
        cmd_next         = cmd_reg;
        cmd_ready_next   = 1'b0;
        psel_next        = 1'b0;
        penable_next     = 1'b0;
        rsp_valid_next   = 1'b0;
        rsp_rdata_next   = '0;
        rsp_err_next     = 1'b0;
        rsp_timeout_next = 1'b0;
        cnt_clear        = 1'b1;
        cnt_enable       = 1'b0;

        case (state_reg)
            IDLE: begin
                cmd_ready_next = 1'b1;
                if (cmd_valid && cmd_ready_reg) begin
                    cmd_next.write = cmd_write;
                    cmd_next.addr  = APB_ADDR_W'(cmd_addr);
                    cmd_next.wdata = APB_DATA_W'(masked_wdata);
                    cmd_next.strb  = APB_STRB_W'(masked_strb);
                    state_next     = SETUP;
                    cmd_ready_next = 1'b0;
                    psel_next      = 1'b1;
                end
            end

            SETUP: begin
                state_next   = ACCESS;
                psel_next    = 1'b1;
                penable_next = 1'b1;
            end

            ACCESS: begin
                cnt_clear    = 1'b0;
                cnt_enable   = 1'b1;
                psel_next    = 1'b1;
                penable_next = 1'b1;
                // pready takes priority over an expiring counter on the same edge.
                if (tim_pready) begin
                    state_next     = IDLE;
                    psel_next      = 1'b0;
                    penable_next   = 1'b0;
                    cmd_ready_next = 1'b1;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = cmd_reg.write ? '0 : tim_prdata;
                    rsp_err_next   = tim_pslverr;
                end else if (cnt_expired) begin
                    state_next       = IDLE;
                    psel_next        = 1'b0;
                    penable_next     = 1'b0;
                    cmd_ready_next   = 1'b1;
                    rsp_valid_next   = 1'b1;
                    rsp_err_next     = 1'b1;
                    rsp_timeout_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg       <= IDLE;
            cmd_reg         <= '0;
            cmd_ready_reg   <= 1'b0;
            psel_reg        <= 1'b0;
            penable_reg     <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_err_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_reg         <= cmd_next;
            cmd_ready_reg   <= cmd_ready_next;
            psel_reg        <= psel_next;
            penable_reg     <= penable_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_timeout_reg <= rsp_timeout_next;
        end
    end

    assign cmd_ready   = cmd_ready_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_rdata   = rsp_rdata_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_timeout = rsp_timeout_reg;
    assign tim_psel    = psel_reg;
    assign tim_penable = penable_reg;
    assign tim_pwrite  = cmd_reg.write;
    assign tim_paddr   = ADDR_W'(cmd_reg.addr);
    assign tim_pwdata  = DATA_W'(cmd_reg.wdata);
    assign tim_pstrb   = STRB_W'(cmd_reg.strb);

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master: bench-driven slave responses, checks sampled on the falling edge.
module tb_apb_cmd_master;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [11:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [11:0] tim_paddr;
    logic        tim_psel;
    logic        tim_penable;
    logic        tim_pwrite;
    logic [31:0] tim_pwdata;
    logic [3:0]  tim_pstrb;
    logic [31:0] tim_prdata;
    logic        tim_pready;
    logic        tim_pslverr;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 sys_clk = ~sys_clk;

    apb_cmd_master #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .TIMEOUT_CYC(8)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .tim_paddr  (tim_paddr),
        .tim_psel   (tim_psel),
        .tim_penable(tim_penable),
        .tim_pwrite (tim_pwrite),
        .tim_pwdata (tim_pwdata),
        .tim_pstrb  (tim_pstrb),
        .tim_prdata (tim_prdata),
        .tim_pready (tim_pready),
        .tim_pslverr(tim_pslverr)
    );

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, tim_psel, tim_penable, tim_pwrite} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {cmd_ready, rsp_valid, rsp_err, rsp_timeout, tim_psel, tim_penable, tim_pwrite});
        end
        tests_run++;
        if ({rsp_rdata, tim_paddr, tim_pwdata, tim_pstrb} !== 80'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 0", {rsp_rdata, tim_paddr, tim_pwdata, tim_pstrb});
        end
        sys_rst = 1'b0;
        tick();
        tests_run++;
        if (cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
        $display("[TB] reset sequence done");
    endtask

    task automatic test_zero_wait_write();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h000;
        cmd_wdata = 32'h0000_0003; cmd_strb = 4'hF;
        tim_pready = 1'b1; tim_pslverr = 1'b0; tim_prdata = 32'hDEAD_BEEF;
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if ({tim_psel, tim_penable, tim_pwrite, cmd_ready} !== 4'b1010) begin
            tests_failed++;
            $display("FAIL zw_setup_ctrl: got %b expected 1010", {tim_psel, tim_penable, tim_pwrite, cmd_ready});
        end
        tests_run++;
        if ({tim_paddr, tim_pwdata, tim_pstrb} !== {12'h000, 32'h0000_0003, 4'hF}) begin
            tests_failed++;
            $display("FAIL zw_setup_data: got %h expected %h", {tim_paddr, tim_pwdata, tim_pstrb},
                     {12'h000, 32'h0000_0003, 4'hF});
        end
        tick();
        tests_run++;
        if ({tim_psel, tim_penable, rsp_valid} !== 3'b110) begin
            tests_failed++;
            $display("FAIL zw_access: got %b expected 110", {tim_psel, tim_penable, rsp_valid});
        end
        tick();
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout, tim_psel, cmd_ready} !== 5'b10001 || rsp_rdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL zw_rsp: got %b rdata %h expected 10001 rdata 00000000",
                     {rsp_valid, rsp_err, rsp_timeout, tim_psel, cmd_ready}, rsp_rdata);
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL zw_rsp_pulse: got %b expected 0", rsp_valid);
        end
        $display("[TB] write addr 000 data 00000003 zero-wait done");
    endtask

    task automatic test_wait_read();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h004;
        cmd_wdata = 32'h1111_2222; cmd_strb = 4'hF;
        tim_pready = 1'b0; tim_pslverr = 1'b1; tim_prdata = 32'hA5A5_1234;
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if ({tim_psel, tim_penable, tim_pwrite} !== 3'b100 || tim_pstrb !== 4'h0 || tim_pwdata !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_setup: got ctrl %b strb %h wdata %h expected 100 0 00000000",
                     {tim_psel, tim_penable, tim_pwrite}, tim_pstrb, tim_pwdata);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            tests_run++;
            if ({tim_psel, tim_penable, tim_pwrite, rsp_valid} !== 4'b1100 || tim_paddr !== 12'h004
                || tim_pstrb !== 4'h0) begin
                tests_failed++;
                $display("FAIL rd_access%0d: got ctrl %b addr %h strb %h expected 1100 004 0", i,
                         {tim_psel, tim_penable, tim_pwrite, rsp_valid}, tim_paddr, tim_pstrb);
            end
            if (i == 3) begin
                tim_pready = 1'b1;
                tim_pslverr = 1'b0;
            end
        end
        tick();
        tim_pready = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'hA5A5_1234) begin
            tests_failed++;
            $display("FAIL rd_rsp: got %b rdata %h expected 100 rdata a5a51234",
                     {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata);
        end
        $display("[TB] read addr 004 two wait states data %h", rsp_rdata);
    endtask

    task automatic test_slverr();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'hFFC;
        cmd_wdata = 32'h0000_00FF; cmd_strb = 4'h1;
        tim_pready = 1'b1; tim_pslverr = 1'b1; tim_prdata = 32'h0;
        tick();
        cmd_valid = 1'b0;
        tests_run++;
        if (tim_paddr !== 12'hFFC || tim_pstrb !== 4'h1) begin
            tests_failed++;
            $display("FAIL err_setup: got addr %h strb %h expected ffc 1", tim_paddr, tim_pstrb);
        end
        tick();
        tick();
        tim_pslverr = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin
            tests_failed++;
            $display("FAIL err_rsp: got %b expected 110", {rsp_valid, rsp_err, rsp_timeout});
        end
        $display("[TB] write addr ffc slave error reported");
    endtask

    task automatic test_timeout(input logic ready_last);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h010;
        cmd_wdata = 32'h0; cmd_strb = 4'h0;
        tim_pready = 1'b0; tim_pslverr = 1'b0; tim_prdata = 32'h0BAD_F00D;
        tick();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            tests_run++;
            if ({tim_psel, tim_penable, rsp_valid} !== 3'b110) begin
                tests_failed++;
                $display("FAIL to_access%0d: got %b expected 110", i, {tim_psel, tim_penable, rsp_valid});
            end
            if (i == 8) tim_pready = ready_last;
        end
        tick();
        tim_pready = 1'b0;
        if (ready_last) begin
            tests_run++;
            if ({rsp_valid, rsp_err, rsp_timeout, tim_psel} !== 4'b1000 || rsp_rdata !== 32'h0BAD_F00D) begin
                tests_failed++;
                $display("FAIL to_edge_rsp: got %b rdata %h expected 1000 rdata 0badf00d",
                         {rsp_valid, rsp_err, rsp_timeout, tim_psel}, rsp_rdata);
            end
            $display("[TB] read addr 010 ready in last cycle completed normally");
        end else begin
            tests_run++;
            if ({rsp_valid, rsp_err, rsp_timeout, tim_psel, tim_penable} !== 5'b11100 || rsp_rdata !== 32'h0) begin
                tests_failed++;
                $display("FAIL to_rsp: got %b rdata %h expected 11100 rdata 00000000",
                         {rsp_valid, rsp_err, rsp_timeout, tim_psel, tim_penable}, rsp_rdata);
            end
            $display("[TB] read addr 010 timed out");
        end
        tick();
        tests_run++;
        if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b000) begin
            tests_failed++;
            $display("FAIL to_rsp_clear: got %b expected 000", {rsp_valid, rsp_err, rsp_timeout});
        end
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h020;
        cmd_wdata = 32'h1234_5678; cmd_strb = 4'hF;
        tim_pready = 1'b0; tim_pslverr = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        tim_pready = 1'b1;
        tests_run++;
        if ({tim_psel, tim_penable, rsp_valid, cmd_ready} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_reset: got %b expected 0000", {tim_psel, tim_penable, rsp_valid, cmd_ready});
        end
        tick();
        tests_run++;
        if ({tim_psel, rsp_valid, cmd_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL mid_reset_after: got %b expected 001", {tim_psel, rsp_valid, cmd_ready});
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_norsp: got %b expected 0", rsp_valid);
        end
        $display("[TB] write addr 020 aborted by reset");
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_psel;
        logic [5:0] exp_pen;
        logic [5:0] exp_rsp;
        exp_psel = 6'b110110;
        exp_pen  = 6'b010010;
        exp_rsp  = 6'b001001;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h030;
        cmd_wdata = 32'hAAAA_0001; cmd_strb = 4'hF;
        tim_pready = 1'b1; tim_pslverr = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (c == 0) begin
                cmd_addr = 12'h034;
                cmd_wdata = 32'hBBBB_0002;
            end
            if (c == 3) cmd_valid = 1'b0;
            tests_run++;
            if ({tim_psel, tim_penable, rsp_valid} !== {exp_psel[5-c], exp_pen[5-c], exp_rsp[5-c]}) begin
                tests_failed++;
                $display("FAIL b2b_cycle%0d: got %b expected %b", c + 1, {tim_psel, tim_penable, rsp_valid},
                         {exp_psel[5-c], exp_pen[5-c], exp_rsp[5-c]});
            end
            if (c == 3) begin
                tests_run++;
                if (tim_paddr !== 12'h034 || tim_pwdata !== 32'hBBBB_0002) begin
                    tests_failed++;
                    $display("FAIL b2b_second_cmd: got addr %h data %h expected 034 bbbb0002",
                             tim_paddr, tim_pwdata);
                end
            end
        end
        tick();
        tests_run++;
        if ({tim_psel, rsp_valid, cmd_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL b2b_idle: got %b expected 001", {tim_psel, rsp_valid, cmd_ready});
        end
        $display("[TB] back-to-back writes 030/034 done");
    endtask

    initial begin
        sys_rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_strb = '0; tim_prdata = '0; tim_pready = 1'b0; tim_pslverr = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_wait_read();
        test_slverr();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB4 requester that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers toward the timer (timer_top).
- It is the initiator end of the APB link the timer responds on, and replaces hand-driven bus sequencing in system integration and benches.
- Returns read data, slave error and timeout status on a one-cycle response pulse.

Parameters:
- ADDR_W, 12, APB address width (matches tim_paddr).
- DATA_W, 32, APB data width; tim_pstrb width is DATA_W/8.
- TIMEOUT_CYC, 16, ACCESS-phase cycles allowed before abort; range 1..255.

Ports:
- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both 1.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte strobes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  captured tim_prdata; 0 for writes and timeouts.
- rsp_err  out  1  tim_pslverr was sampled high, or a timeout occurred.
- rsp_timeout  out  1  transfer was aborted by the timeout.
- tim_paddr  out  ADDR_W  APB address.
- tim_psel  out  1  APB select.
- tim_penable  out  1  APB enable.
- tim_pwrite  out  1  APB direction.
- tim_pwdata  out  DATA_W  APB write data.
- tim_pstrb  out  DATA_W/8  APB strobes.
- tim_prdata  in  DATA_W  APB read data.
- tim_pready  in  1  APB ready.
- tim_pslverr  in  1  APB slave error.

Behaviour:
- Reset (sys_rst=1 at an edge) sets state IDLE and drives every output to 0, including cmd_ready. cmd_ready rises on the first edge after sys_rst drops.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready=1, tim_psel=0, tim_penable=0.
  - On handshake, register addr, write, wdata and strb, then go to SETUP.
  - For reads, the registered strb is 0 and the registered wdata is 0.
- SETUP (exactly one cycle): tim_psel=1, tim_penable=0, tim_paddr/tim_pwrite/tim_pwdata/tim_pstrb carry the registered command; cmd_ready=0. Next state is ACCESS.
- ACCESS:
  - tim_psel=1, tim_penable=1; all address, data and control outputs held stable.
  - The timeout counter counts ACCESS cycles starting from 1.
  - On an edge where tim_pready=1: capture tim_prdata (reads only) and tim_pslverr, go to IDLE, and pulse rsp_valid for the following cycle.
  - If the counter reaches TIMEOUT_CYC with tim_pready=0: drop psel/penable, go to IDLE, pulse rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- If tim_pready=1 on the same edge the counter reaches TIMEOUT_CYC, pready wins: normal completion, no timeout.
- Latency:
  - Handshake at edge N, SETUP in cycle N+1, ACCESS from cycle N+2.
  - With zero wait states, rsp_valid is high in cycle N+3.
  - Each wait state adds one cycle.
- Back-to-back transfers:
  - cmd_ready is high in the same cycle as rsp_valid (state is IDLE), so the next SETUP can follow immediately.
  - Minimum of 3 cycles per transfer; psel drops for at least one cycle between transfers.
- Response outputs:
  - rsp_rdata, rsp_err and rsp_timeout are valid only while rsp_valid=1 and are cleared to 0 otherwise.
  - There is no response backpressure; the consumer must take the pulse.
- tim_pslverr is sampled only on the completing edge (psel & penable & pready) and ignored otherwise.
- tim_prdata is ignored for writes.
- Reset in mid-transfer (SETUP or ACCESS) returns to IDLE with outputs 0 on that edge. No rsp_valid is generated for the aborted command.
- cmd_* inputs are ignored while cmd_ready=0.

Decomposition:
- Package apb_pkg holds:
  - APB_ADDR_W=12 and APB_DATA_W=32.
  - The state enum apb_state_t {IDLE, SETUP, ACCESS}.
  - A packed apb_cmd_t struct {write, addr, wdata, strb}.
- One sub-module, apb_timeout_cnt: an 8-bit counter with clear/enable inputs and an expired flag at TIMEOUT_CYC, instantiated once.
- The FSM and output registers stay in apb_cmd_master.

Test Plan:
- Reset: hold sys_rst for 2 cycles → all outputs 0; cmd_ready=1 one cycle after release.
- Zero-wait write: addr 0x000, wdata 0x0000_0003, strb 0xF, slave pready=1 → one SETUP cycle (psel=1, penable=0), one ACCESS cycle, rsp_valid at handshake+3, rsp_err=0, rsp_rdata=0.
- Read with 2 wait states: addr 0x004, slave returns 0xA5A5_1234 with pready asserted in the 3rd ACCESS cycle → addr/control stable for 3 ACCESS cycles, tim_pstrb=0, rsp_rdata=0xA5A5_1234 at handshake+5.
- Slave error: write to addr 0xFFC with pslverr=1 and pready=1 → rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT_CYC=8, pready held 0 → psel/penable drop after the 8th ACCESS cycle, rsp_valid with rsp_err=1, rsp_timeout=1, rsp_rdata=0. A second run raises pready exactly in the 8th cycle → normal completion.
- Reset and back-to-back:
  - Assert sys_rst during ACCESS → psel=0 next edge, no rsp_valid.
  - Then issue two commands back to back, cmd_valid held → the second SETUP directly follows the first rsp_valid cycle; 6 cycles total for two zero-wait transfers.
